// File: rtl/ice_ddr_io_bank.sv
// WIDTH-lane registered DDR pad bank with per-lane enables, async-reset tri-state and 2:1 input bit-slip.
// Output: 0 cycles after the launching rise; input: DIN pair valid 1 cycle after r_k; no backpressure, CE freezes all state.
module ice_ddr_io_bank #(
  parameter int WIDTH       = 4,
  parameter int OUT_MODE    = 2,
  parameter int OE_REG      = 1,
  parameter int NEG_TRIGGER = 0,
  parameter int PULLUP      = 0
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             CLOCKENABLE,
  input  logic [WIDTH-1:0] OUTPUTENABLE,
  input  logic [WIDTH-1:0] DOUT0,
  input  logic [WIDTH-1:0] DOUT1,
  input  logic             LATCHINPUTVALUE,
  input  logic             BITSLIP,
  output logic [WIDTH-1:0] DIN0,
  output logic [WIDTH-1:0] DIN1,
  output logic             DIN_VALID,
  output logic             SLIP_STATE,
  inout  wire  [WIDTH-1:0] PACKAGEPIN,
  output logic [WIDTH-1:0] GLOBALBUFFEROUTPUT
);

  localparam logic CLK_INV = (NEG_TRIGGER != 0);

  logic             clk_i;
  logic             ce_q;
  logic [WIDTH-1:0] do0_q;
  logic [WIDTH-1:0] do1_q;
  logic [WIDTH-1:0] do1_n;
  logic [WIDTH-1:0] oe_q;
  logic [WIDTH-1:0] oe;
  logic [WIDTH-1:0] pad_dat;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] f_q;
  logic [WIDTH-1:0] fr_q;
  logic [1:0]       guard;
  logic [1:0]       guard_nxt;
  logic             slip_q;
  logic             slip_nxt;
  logic             started;

  assign clk_i = CLK ^ CLK_INV;

  // Guard blocks re-slips while the capture pipe refills; the first enabled rise after reset arms it.
  always_comb begin
    guard_nxt = guard;
    slip_nxt  = slip_q;
    if (!started) begin
      guard_nxt = 2'd2;
    end else if (guard != 2'd0) begin
      guard_nxt = guard - 2'd1;
    end else if (BITSLIP) begin
      guard_nxt = 2'd2;
      slip_nxt  = ~slip_q;
    end
  end

  always_ff @(posedge clk_i or negedge RESETN) begin
    if (!RESETN) begin
      ce_q      <= 1'b0;
      do0_q     <= '0;
      do1_q     <= '0;
      oe_q      <= '0;
      r_q       <= '0;
      fr_q      <= '0;
      DIN0      <= '0;
      DIN1      <= '0;
      DIN_VALID <= 1'b0;
      slip_q    <= 1'b0;
      guard     <= 2'd0;
      started   <= 1'b0;
    end else begin
      ce_q <= CLOCKENABLE;
      if (CLOCKENABLE) begin
        do0_q   <= DOUT0;
        do1_q   <= DOUT1;
        oe_q    <= OUTPUTENABLE;
        r_q     <= PACKAGEPIN;
        fr_q    <= f_q;
        started <= 1'b1;
        guard   <= guard_nxt;
        slip_q  <= slip_nxt;
        if (!LATCHINPUTVALUE) begin
          DIN0      <= slip_q ? fr_q : r_q;
          DIN1      <= slip_q ? r_q  : f_q;
          DIN_VALID <= (guard_nxt == 2'd0);
        end
      end
    end
  end

  // Fall stage is gated by the CE seen at the preceding rise so a held cycle repeats its whole pair.
  always_ff @(negedge clk_i or negedge RESETN) begin
    if (!RESETN) begin
      do1_n <= '0;
      f_q   <= '0;
    end else if (ce_q) begin
      do1_n <= do1_q;
      f_q   <= PACKAGEPIN;
    end
  end

  generate
    if (OUT_MODE == 0) begin : g_out_comb
      assign pad_dat = DOUT0;
    end else if (OUT_MODE == 1) begin : g_out_sdr
      assign pad_dat = do0_q;
    end else begin : g_out_ddr
      assign pad_dat = clk_i ? do0_q : do1_n;
    end

    // RESETN gates the enables directly so pads float in the same delta as reset assertion.
    if (OE_REG != 0) begin : g_oe_reg
      assign oe = oe_q & {WIDTH{RESETN}};
    end else begin : g_oe_comb
      assign oe = OUTPUTENABLE & {WIDTH{RESETN}};
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      assign PACKAGEPIN[i] = oe[i] ? pad_dat[i] : 1'bz;
      if (PULLUP != 0) begin : g_pu
        pullup pu (PACKAGEPIN[i]);
      end
    end
  endgenerate

  assign GLOBALBUFFEROUTPUT = PACKAGEPIN;
  assign SLIP_STATE         = slip_q;

endmodule

// File: tb/tb_ice_ddr_io_bank.sv
// Directed bench for ice_ddr_io_bank: pull-ups make floating lanes read 1, loopback pad driven by the bench.
module tb_ice_ddr_io_bank;

  logic       CLK;
  logic       RESETN;
  logic       ce;
  logic [3:0] oe_in;
  logic [3:0] dout0;
  logic [3:0] dout1;
  logic       latch;
  logic       bitslip;
  logic [3:0] din0, din1, gbo;
  logic       din_valid, slip;
  logic [3:0] din0_n, din1_n, gbo_n;
  logic       din_valid_n, slip_n;
  wire  [3:0] pad;
  wire  [3:0] pad_n;

  logic       drv_en;
  logic [3:0] pad_drv;
  logic [3:0] rise_val;
  logic [3:0] fall_val;

  typedef struct packed {
    logic [3:0] d0;
    logic [3:0] d1;
  } din_t;
  din_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  ice_ddr_io_bank #(.WIDTH(4), .OUT_MODE(2), .OE_REG(1), .NEG_TRIGGER(0), .PULLUP(1)) u_dut (
    .CLK(CLK), .RESETN(RESETN), .CLOCKENABLE(ce), .OUTPUTENABLE(oe_in),
    .DOUT0(dout0), .DOUT1(dout1), .LATCHINPUTVALUE(latch), .BITSLIP(bitslip),
    .DIN0(din0), .DIN1(din1), .DIN_VALID(din_valid), .SLIP_STATE(slip),
    .PACKAGEPIN(pad), .GLOBALBUFFEROUTPUT(gbo)
  );

  ice_ddr_io_bank #(.WIDTH(4), .OUT_MODE(2), .OE_REG(1), .NEG_TRIGGER(1), .PULLUP(1)) u_neg (
    .CLK(CLK), .RESETN(RESETN), .CLOCKENABLE(ce), .OUTPUTENABLE(oe_in),
    .DOUT0(dout0), .DOUT1(dout1), .LATCHINPUTVALUE(latch), .BITSLIP(bitslip),
    .DIN0(din0_n), .DIN1(din1_n), .DIN_VALID(din_valid_n), .SLIP_STATE(slip_n),
    .PACKAGEPIN(pad_n), .GLOBALBUFFEROUTPUT(gbo_n)
  );

  assign pad = drv_en ? pad_drv : 4'bzzzz;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Loopback source: rise value is stable around each posedge, fall value around each negedge.
  always @(posedge CLK) begin
    #2;
    pad_drv = fall_val;
  end
  always @(negedge CLK) begin
    #2;
    pad_drv = rise_val;
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {3'b000, obs}, {3'b000, exp});
  endtask

  task automatic sb_push(input logic [3:0] d0, input logic [3:0] d1);
    din_t e;
    e.d0 = d0;
    e.d1 = d1;
    exp_q.push_back(e);
  endtask

  task automatic sb_check(input string tag);
    din_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_din0"}, din0, e.d0);
      chk({tag, "_din1"}, din1, e.d1);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic half();
    @(negedge CLK);
    #1;
  endtask

  initial begin
    int   toggles;
    logic prev;

    RESETN   = 1'b0;
    ce       = 1'b1;
    oe_in    = 4'hF;
    dout0    = 4'h0;
    dout1    = 4'h0;
    latch    = 1'b0;
    bitslip  = 1'b0;
    drv_en   = 1'b0;
    pad_drv  = 4'h0;
    rise_val = 4'h0;
    fall_val = 4'h0;

    // Reset: pads float (pulled high) even with all enables requested.
    repeat (2) step();
    chk("rst_pad", pad, 4'hF);
    chk("rst_gbo", gbo, 4'hF);
    chk("rst_pad_neg", pad_n, 4'hF);
    chk("rst_din0", din0, 4'h0);
    chk("rst_din1", din1, 4'h0);
    chk1("rst_valid", din_valid, 1'b0);
    chk1("rst_slip", slip, 1'b0);

    RESETN = 1'b1;
    step();
    chk1("rel_valid_r1", din_valid, 1'b0);
    chk("first_out_zero", pad, 4'h0);
    step();
    chk1("rel_valid_r2", din_valid, 1'b0);
    step();
    chk1("rel_valid_r3", din_valid, 1'b1);

    // DDR output, both clock polarities, then partial enables.
    dout0 = 4'hA;
    dout1 = 4'h5;
    step();
    chk("ddr_hi", pad, 4'hA);
    chk("ddr_gbo_hi", gbo, 4'hA);
    chk("neg_ddr_lo", pad_n, 4'h5);
    half();
    chk("ddr_lo", pad, 4'h5);
    chk("neg_ddr_hi", pad_n, 4'hA);
    oe_in = 4'h3;
    step();
    chk("oe3_hi", pad, 4'hE);
    chk("oe3_gbo_hi", gbo, 4'hE);
    half();
    chk("oe3_lo", pad, 4'hD);
    chk("neg_oe3_hi", pad_n, 4'hE);
    step();
    chk("neg_oe3_lo", pad_n, 4'hD);
    oe_in = 4'hF;
    step();

    // Clock enable low for two cycles: pair repeats and a BITSLIP pulse is dropped.
    ce      = 1'b0;
    dout0   = 4'h3;
    dout1   = 4'hC;
    bitslip = 1'b1;
    step();
    bitslip = 1'b0;
    chk("ce0_hi1", pad, 4'hA);
    chk1("ce0_slip_blocked", slip, 1'b0);
    half();
    chk("ce0_lo1", pad, 4'h5);
    step();
    chk("ce0_hi2", pad, 4'hA);
    half();
    chk("ce0_lo2", pad, 4'h5);
    ce = 1'b1;
    step();
    chk("ce1_hi", pad, 4'h3);
    half();
    chk("ce1_lo", pad, 4'hC);
    chk1("ce1_slip", slip, 1'b0);

    // Loopback r=1,f=0 then a single bit-slip.
    oe_in = 4'h0;
    dout0 = 4'h0;
    dout1 = 4'h0;
    step();
    drv_en   = 1'b1;
    rise_val = 4'hF;
    fall_val = 4'h0;
    sb_push(4'hF, 4'h0);
    repeat (3) step();
    sb_check("loop_s0");
    chk1("loop_s0_slip", slip, 1'b0);
    chk1("loop_s0_valid", din_valid, 1'b1);
    bitslip = 1'b1;
    step();
    bitslip = 1'b0;
    chk1("slip_toggled", slip, 1'b1);
    chk1("slip_valid_lo1", din_valid, 1'b0);
    step();
    chk1("slip_valid_lo2", din_valid, 1'b0);
    step();
    chk1("slip_valid_hi", din_valid, 1'b1);
    sb_push(4'h0, 4'hF);
    sb_check("loop_s1");

    // BITSLIP held for six rises: toggles at the 1st and 4th only.
    toggles = 0;
    prev    = 1'b1;
    bitslip = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (slip !== prev) toggles++;
      prev = slip;
    end
    bitslip = 1'b0;
    chk("hold_toggles", 4'(toggles), 4'd2);
    chk1("hold_slip_back", slip, 1'b1);
    chk1("hold_valid", din_valid, 1'b1);

    // Latch: outputs freeze while the pad goes 0 -> F; a slip is still taken.
    rise_val = 4'h0;
    fall_val = 4'h0;
    sb_push(4'h0, 4'h0);
    repeat (3) step();
    sb_check("pre_latch");
    latch    = 1'b1;
    rise_val = 4'hF;
    fall_val = 4'hF;
    bitslip  = 1'b1;
    step();
    bitslip = 1'b0;
    sb_push(4'h0, 4'h0);
    sb_check("latch1");
    chk1("latch_slip_taken", slip, 1'b0);
    chk1("latch1_valid_held", din_valid, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step();
      sb_push(4'h0, 4'h0);
      sb_check("latch_hold");
      chk1("latch_valid_held", din_valid, 1'b1);
    end
    latch = 1'b0;
    step();
    sb_push(4'hF, 4'hF);
    sb_check("latch_release");
    chk1("release_valid", din_valid, 1'b1);

    // Reset in the low phase of a DDR cycle floats the pads immediately.
    drv_en = 1'b0;
    oe_in  = 4'hF;
    dout0  = 4'hA;
    dout1  = 4'h5;
    step();
    chk("pre_mid_rst_hi", pad, 4'hA);
    half();
    chk("pre_mid_rst_lo", pad, 4'h5);
    RESETN = 1'b0;
    #1;
    chk("mid_rst_pad", pad, 4'hF);
    chk("mid_rst_din0", din0, 4'h0);
    chk1("mid_rst_valid", din_valid, 1'b0);
    chk1("mid_rst_slip", slip, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
